sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
- Parametrised successor to the board's single-word RAM1 access controller.
- Converts a valid/ready request interface (read or write, one word) into timed active-low SRAM strobes on a shared tri-state data bus.
- Access width and strobe wait-state count are configurable.
- Sits between the CPU memory stage or switch-driven debug logic and the external RAM1 pins.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, cycles the OE or WE strobe is held low. Legal range 1..15; elaboration error outside it.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle pulse: read data valid, or write complete.
- rsp_rdata  output  DATA_W  read data; holds its value until the next read completes.
- RamAddr  output  ADDR_W  SRAM address pins.
- RamData  inout  DATA_W  SRAM data bus.
- RamOE  output  1  output enable, active-low.
- RamWE  output  1  write enable, active-low.
- RamEN  output  1  chip enable, active-low.

Behaviour:
- Reset values (synchronous, one edge with RST=1):
  - state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; RamAddr=0.
  - RamOE=RamWE=RamEN=1; RamData high-Z.
- RST overrides everything, including mid-access. The edge with RST=1 deasserts all strobes and releases the bus; no rsp_valid is produced for the aborted access.
- All outputs are registered. RamData is driven only from a registered drive-enable.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on an edge with req_valid&&req_ready.
  - req_addr, req_we and req_wdata are captured into internal registers at acceptance; inputs are don't-care afterwards.
  - req_valid while busy is ignored. The requester must hold it until accepted.
- States:
  - IDLE: strobes high, bus Z. On accept: read goes to RD_STROBE, write goes to WR_SETUP.
  - RD_STROBE: RamEN=0, RamOE=0, RamAddr=captured address, bus Z. Lasts WAIT_CYCLES cycles, counted by a 4-bit counter. On the edge ending the last cycle:
    - RamData is sampled into rsp_rdata;
    - next state IDLE with rsp_valid=1 and RamOE/RamEN=1.
  - WR_SETUP (1 cycle): RamEN=0, RamWE=1, RamAddr and RamData driven with captured values.
  - WR_PULSE (WAIT_CYCLES cycles): RamWE=0; address and data held.
  - WR_HOLD (1 cycle): RamWE=1, RamEN=0, data still driven. Next state IDLE with rsp_valid=1, RamEN=1, bus Z.
- RamOE and RamWE are never low in the same cycle. The bus is never driven while RamOE=0.
- Latency, with acceptance on edge k:
  - read: rsp_valid high in cycle k+WAIT_CYCLES;
  - write: rsp_valid high in cycle k+WAIT_CYCLES+2.
- rsp_valid is high for exactly one cycle and coincides with the return to IDLE (req_ready=1). A new request accepted in that same cycle starts immediately: back-to-back accesses have zero idle gap.
- rsp_rdata is unchanged by writes.
- Address is passed through unmodified; no wrap or increment. All-ones address is legal.

Test Plan:
- Reset: hold RST=1 for 2 cycles with req_valid=1 -> req_ready=1, rsp_valid=0, rsp_rdata=0, RamOE/RamWE/RamEN=1, RamData=Z, no access started.
- Write then read, WAIT_CYCLES=2:
  - write addr 0x00123, data 0xBEEF -> RamWE low for exactly 2 cycles, data stable from WR_SETUP through WR_HOLD, rsp_valid at k+4;
  - read 0x00123 from the SRAM model -> RamOE low 2 cycles, rsp_rdata=0xBEEF, rsp_valid at k+2.
- Back-to-back: four reads to 0x3FFFF, 0x00000, 0x00001, 0x3FFFE with req_valid held high -> each accepted in its predecessor's rsp_valid cycle, 4 pulses with no gap cycles, data matches the model.
- Busy-ignore: during a write, change req_addr/req_wdata every cycle with req_valid=1 -> the SRAM sees only the captured values; the next request is accepted only after rsp_valid.
- Reset mid-access: assert RST during the second WR_PULSE cycle -> next cycle RamWE=1, RamEN=1, bus Z, no rsp_valid; a following read completes normally.
- Parameter sweep WAIT_CYCLES=1 and 15, DATA_W=8, ADDR_W=20 -> strobe widths 1 and 15 cycles; read/write latencies of 1/3 and 15/17 cycles; no OE/WE overlap (assertion).

Source files
------------

// File: rtl/sram_access_ctrl.sv
// SRAM access controller: valid/ready single-word requests mapped onto
// timed active-low RAM1 strobes over a shared tri-state data bus.
module sram_access_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] RamAddr,
  inout  wire  [DATA_W-1:0] RamData,
  output logic              RamOE,
  output logic              RamWE,
  output logic              RamEN
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_access_ctrl: WAIT_CYCLES must be within 1..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] wdata;
  logic              drive;
  logic              accept;

  assign accept  = req_valid & req_ready;
  // Bus is driven only from the registered enable, never while OE is low.
  assign RamData = drive ? wdata : 'z;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      wdata     <= '0;
      drive     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      RamAddr   <= '0;
      RamOE     <= 1'b1;
      RamWE     <= 1'b1;
      RamEN     <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            RamAddr   <= req_addr;
            RamEN     <= 1'b0;
            cnt       <= CNT_LAST;
            if (req_we) begin
              state <= WR_SETUP;
              wdata <= req_wdata;
              drive <= 1'b1;
            end else begin
              state <= RD_STROBE;
              RamOE <= 1'b0;
            end
          end
        end
        RD_STROBE: begin
          if (cnt == '0) begin
            state     <= IDLE;
            rsp_rdata <= RamData;
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
            RamOE     <= 1'b1;
            RamEN     <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_SETUP: begin
          state <= WR_PULSE;
          RamWE <= 1'b0;
        end
        WR_PULSE: begin
          if (cnt == '0) begin
            state <= WR_HOLD;
            RamWE <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_HOLD: begin
          state     <= IDLE;
          drive     <= 1'b0;
          rsp_valid <= 1'b1;
          req_ready <= 1'b1;
          RamEN     <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl over three parameter sets,
// each with its own SRAM model and behavioural reference memory.
module tb_sram_access_ctrl;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    longint      t;
  } exp_t;

  logic CLK;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done [3];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input bit ok,
                     input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W  = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    localparam int DW = (g == 0) ? 16 : 8;
    localparam int AW = (g == 0) ? 18 : 20;

    logic          rst, req_valid, req_ready, req_we, rsp_valid;
    logic          RamOE, RamWE, RamEN;
    logic [AW-1:0] req_addr, RamAddr;
    logic [DW-1:0] req_wdata, rsp_rdata, sram_q, last_rd;
    wire  [DW-1:0] RamData;

    exp_t          exp_q [$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    longint        t_acc;
    int            oe_run = 0;
    int            we_run = 0;

    sram_access_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)
    ) dut (
      .CLK(CLK), .RST(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .RamAddr(RamAddr), .RamData(RamData),
      .RamOE(RamOE), .RamWE(RamWE), .RamEN(RamEN)
    );

    // Power-on contents of locations never written.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return DW'(32'(a) * 13 + 1);
    endfunction

    // Asynchronous SRAM: drives while selected and OE low, stores while WE low.
    assign RamData = (!RamEN && !RamOE) ? sram_q : 'z;
    always @(negedge CLK) begin
      if (!RamEN && !RamWE) mem[RamAddr] = RamData;
      sram_q = mem.exists(RamAddr) ? mem[RamAddr] : init_val(RamAddr);
    end

    task automatic issue(input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit keep,
                         input bit scr);
      int   n = 0;
      exp_t e;
      @(negedge CLK);
      while (!req_ready && n < 100) begin
        if (scr) begin
          req_we    = 1'($urandom);
          req_addr  = AW'($urandom);
          req_wdata = DW'($urandom);
        end
        @(negedge CLK);
        n++;
      end
      chk("accept_wait", req_ready, 32'(n), 32'd100);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(posedge CLK);
      t_acc = $time;
      if (we) ref_mem[a] = d;
      else last_rd = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
      e.we    = we;
      e.addr  = 32'(a);
      e.wdata = 32'(d);
      e.rdata = 32'(last_rd);
      e.t     = $time;
      exp_q.push_back(e);
      #1;
      if (!keep) req_valid = 1'b0;
    endtask

    always @(negedge CLK) begin
      exp_t   e;
      longint lat;
      if (rst) begin
        oe_run = 0;
        we_run = 0;
      end else begin
        chk("oe_we_overlap", RamOE || RamWE, {30'd0, RamOE, RamWE}, 32'd3);
        if (!RamOE) begin
          oe_run++;
          chk("rd_en", !RamEN, 32'(RamEN), 32'd0);
          if (exp_q.size() != 0)
            chk("rd_addr", 32'(RamAddr) == exp_q[0].addr,
                32'(RamAddr), exp_q[0].addr);
        end else if (oe_run != 0) begin
          chk("oe_width", oe_run == W, 32'(oe_run), 32'(W));
          oe_run = 0;
        end
        if (!RamWE) begin
          we_run++;
          chk("wr_en", !RamEN, 32'(RamEN), 32'd0);
          if (exp_q.size() != 0) begin
            chk("wr_addr", 32'(RamAddr) == exp_q[0].addr,
                32'(RamAddr), exp_q[0].addr);
            chk("wr_data", 32'(RamData) == exp_q[0].wdata,
                32'(RamData), exp_q[0].wdata);
          end
        end else if (we_run != 0) begin
          chk("we_width", we_run == W, 32'(we_run), 32'(W));
          we_run = 0;
        end
        if (rsp_valid) begin
          chk("rsp_pending", exp_q.size() != 0, 32'(exp_q.size()), 32'd1);
          if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            lat = ($time - e.t - 5) / 10;
            chk(e.we ? "wr_latency" : "rd_latency",
                lat == (e.we ? W + 2 : W), 32'(lat), 32'(e.we ? W + 2 : W));
            chk("rsp_rdata", 32'(rsp_rdata) == e.rdata,
                32'(rsp_rdata), e.rdata);
          end
        end
      end
    end

    initial begin
      longint        ta [4];
      logic [AW-1:0] b2b [4];
      rst       = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = '1;
      req_wdata = '1;
      last_rd   = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", req_ready == 1'b1, 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", rsp_valid == 1'b0, 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata == '0, 32'(rsp_rdata), 32'd0);
      chk("rst_strobes", {RamOE, RamWE, RamEN} == 3'b111,
          32'({RamOE, RamWE, RamEN}), 32'd7);
      chk("rst_addr", RamAddr == '0, 32'(RamAddr), 32'd0);
      req_valid = 1'b0;
      rst       = 1'b0;

      issue(1'b1, AW'(20'h00123), DW'(16'hBEEF), 1'b0, 1'b0);
      issue(1'b0, AW'(20'h00123), '0, 1'b0, 1'b0);

      b2b[0] = '1;
      b2b[1] = '0;
      b2b[2] = AW'(1);
      b2b[3] = ~AW'(1);
      for (int i = 0; i < 4; i++) begin
        issue(1'b0, b2b[i], '0, i < 3, 1'b0);
        ta[i] = t_acc;
      end
      for (int i = 1; i < 4; i++)
        chk("b2b_gap", ta[i] - ta[i-1] == (W + 1) * 10,
            32'(ta[i] - ta[i-1]), 32'((W + 1) * 10));

      issue(1'b1, AW'(5), DW'(16'h5AA5), 1'b1, 1'b0);
      ta[0] = t_acc;
      issue(1'b0, AW'(5), '0, 1'b0, 1'b1);
      chk("busy_accept", t_acc - ta[0] == (W + 3) * 10,
          32'(t_acc - ta[0]), 32'((W + 3) * 10));

      issue(1'b1, AW'(8'h40), DW'(16'h1234), 1'b0, 1'b0);
      repeat ((W >= 2) ? 2 : 1) @(posedge CLK);
      #1 rst = 1'b1;
      @(posedge CLK);
      #1 rst = 1'b0;
      exp_q.delete();
      ref_mem.delete(AW'(8'h40));
      last_rd = '0;
      @(negedge CLK);
      chk("abort_we", RamWE == 1'b1, 32'(RamWE), 32'd1);
      chk("abort_en", RamEN == 1'b1, 32'(RamEN), 32'd1);
      chk("abort_ready", req_ready == 1'b1, 32'(req_ready), 32'd1);
      chk("abort_rdata", rsp_rdata == '0, 32'(rsp_rdata), 32'd0);
      issue(1'b0, AW'(20'h00123), '0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++)
        issue(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
              (i < 39) && ($urandom_range(0, 1) == 1),
              1'($urandom));

      repeat (2 * W + 10) @(posedge CLK);
      @(negedge CLK);
      chk("drain", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    int c = 0;
    while (!(done[0] && done[1] && done[2]) && c < 20000) begin
      @(posedge CLK);
      c++;
    end
    chk("all_done", done[0] && done[1] && done[2], 32'(c), 32'd20000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
